// File: rtl/ccff_chain_loader_if.sv
// rtl/ccff_chain_loader_if.sv - host word stream into the ccff chain loader
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
) ();
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;

    modport master (output word_valid, output word_data, input word_ready);
    modport slave  (input word_valid, input word_data, output word_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serializes host words MSB-first onto a ccff chain for CHAIN_LEN shifts
// Optional tail-compare verify pass is built only when CCFF_VERIFY_EN is defined.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                start,
    input  logic                verify,
    ccff_chain_loader_if.slave  word_if,
    output logic                ccff_head,
    input  logic                ccff_tail,
    output logic                prog_clk_en,
    output logic                config_enable,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    mismatch_cnt
);
    localparam int SH_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WORD_W-1:0] r_shift;
    logic [SH_W-1:0]   r_sh_cnt;
    logic [CNT_W-1:0]  r_fetch;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_busy;
    logic              r_cfg;
    logic              r_done;
    logic              w_shift;
    logic              w_ready;
    logic              w_accept;
    logic              w_start;
    logic [SH_W-1:0]   w_take;
    int                w_rem;

    // The final word may be only partly needed; only its top bits are counted in.
    always_comb begin
        w_rem  = CHAIN_LEN - int'(r_fetch);
        w_take = (w_rem < WORD_W) ? SH_W'(w_rem) : SH_W'(WORD_W);
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_shift = 1'b0;
        w_ready = 1'b0;
        w_start = 1'b0;
        case (r_state)
            IDLE: begin
                w_start = start;
                if (start) w_next = LOAD;
            end
            LOAD: begin
                w_shift = (r_sh_cnt != '0);
                w_ready = (r_fetch < CNT_W'(CHAIN_LEN)) && (r_sh_cnt <= SH_W'(1));
                if (w_shift && (r_bit_cnt == CNT_W'(CHAIN_LEN - 1))) w_next = DONE;
            end
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_accept           = w_ready && word_if.word_valid;
    assign word_if.word_ready = w_ready;
    assign prog_clk_en        = w_shift;
    assign ccff_head          = r_shift[WORD_W-1];
    assign config_enable      = r_cfg;
    assign busy               = r_busy;
    assign done               = r_done;

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_shift   <= '0;
            r_sh_cnt  <= '0;
            r_fetch   <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_cfg     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_busy <= (w_next != IDLE);
            r_cfg  <= (w_next != IDLE);
            r_done <= (w_next == DONE);
            if (w_start) begin
                r_shift   <= '0;
                r_sh_cnt  <= '0;
                r_fetch   <= '0;
                r_bit_cnt <= '0;
            end else begin
                if (w_shift) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                // A new word overwrites the register on the edge its last old bit leaves.
                if (w_accept) begin
                    r_shift  <= word_if.word_data;
                    r_sh_cnt <= w_take;
                    r_fetch  <= r_fetch + CNT_W'(w_take);
                end else if (w_shift) begin
                    r_shift  <= {r_shift[WORD_W-2:0], 1'b0};
                    r_sh_cnt <= r_sh_cnt - SH_W'(1);
                end
            end
        end
    end

`ifdef CCFF_VERIFY_EN
    logic             r_vmode;
    logic [CNT_W-1:0] r_mm;

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_vmode <= 1'b0;
            r_mm    <= '0;
        end else if (w_start) begin
            r_vmode <= verify;
            r_mm    <= '0;
        end else if (w_shift && r_vmode && (ccff_tail != r_shift[WORD_W-1]) && (r_mm != '1)) begin
            r_mm <= r_mm + CNT_W'(1);
        end
    end

    assign mismatch_cnt = r_mm;
`else
    logic w_unused;
    assign w_unused     = ^{verify, ccff_tail};
    assign mismatch_cnt = '0;
`endif
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - self-checking bench for ccff_chain_loader with a 20-FF chain model
module tb_ccff_chain_loader;
    localparam int CL = 20;
    localparam int WW = 8;
    localparam int CW = $clog2(CL + 1);
`ifdef CCFF_VERIFY_EN
    localparam bit VEN = 1'b1;
`else
    localparam bit VEN = 1'b0;
`endif

    typedef struct {
        logic [23:0] words;
        bit          vfy;
        int          gap;
        bit          poke;
        int          exp_mm;
        string       tag;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          verify = 1'b0;
    logic          ccff_head, ccff_tail, prog_clk_en, config_enable, busy, done;
    logic [CW-1:0] mismatch_cnt;
    logic [CL-1:0] chain = '0;
    bit            exp_q[$];
    vec_t          vecs[6];
    int            total = 0;
    int            bad = 0;
    int            m_shifts, m_first, m_done_n, m_stall, m_busy_cyc;
    logic [CW-1:0] m_mm;

    always #5 clk = ~clk;

    ccff_chain_loader_if #(.WORD_W(WW)) wif ();

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk      (clk),
        .pReset        (rst),
        .start         (start),
        .verify        (verify),
        .word_if       (wif),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .prog_clk_en   (prog_clk_en),
        .config_enable (config_enable),
        .busy          (busy),
        .done          (done),
        .mismatch_cnt  (mismatch_cnt)
    );

    // Chain under programming: newest bit at [0], tail is the bit loaded CL shifts ago.
    assign ccff_tail = chain[CL-1];
    always @(posedge clk) if (prog_clk_en === 1'b1) chain <= {chain[CL-2:0], ccff_head};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic start_pass(input bit v);
        @(negedge clk);
        start  = 1'b1;
        verify = v;
        @(negedge clk);
        start  = 1'b0;
        verify = 1'b0;
    endtask

    task automatic run_pass(input vec_t t);
        int            g;
        int            tmo;
        int            n;
        bit            eb;
        logic [CL-1:0] exp_chain;
        exp_q.delete();
        for (int i = 0; i < CL; i++) exp_q.push_back(t.words[23-i]);
        exp_chain = t.words[23 -: CL];
        start_pass(t.vfy);
        fork
            begin : host
                for (int i = 0; i < 3; i++) begin
                    if (i == 1 && t.gap > 0) begin
                        wif.word_valid = 1'b0;
                        g = 0;
                        while (g < t.gap) begin
                            if (wif.word_ready) g++;
                            @(negedge clk);
                        end
                    end
                    wif.word_valid = 1'b1;
                    wif.word_data  = t.words[23-8*i -: 8];
                    tmo = 0;
                    while (!wif.word_ready && tmo < 100) begin
                        @(negedge clk);
                        tmo++;
                    end
                    if (tmo >= 100) check({t.tag, " host ready timeout"}, 0, 1);
                    @(negedge clk);
                end
                wif.word_valid = 1'b0;
            end
            begin : mon
                n = 1; m_shifts = 0; m_first = -1; m_stall = 0; m_busy_cyc = 0; m_done_n = -1;
                while (m_done_n < 0 && n <= 200) begin
                    if (busy && config_enable) m_busy_cyc++;
                    if (prog_clk_en) begin
                        m_shifts++;
                        if (m_first < 0) m_first = n;
                        if (exp_q.size() > 0) begin
                            eb = exp_q.pop_front();
                            check({t.tag, " head bit"}, ccff_head, eb);
                        end else begin
                            check({t.tag, " extra shift"}, 1, 0);
                        end
                    end else if (m_shifts > 0 && m_shifts < CL) begin
                        m_stall++;
                    end
                    if (done) begin
                        m_done_n = n;
                        m_mm     = mismatch_cnt;
                    end else begin
                        @(negedge clk);
                        n++;
                    end
                end
            end
            begin : poke
                if (t.poke) begin
                    repeat (4) @(negedge clk);
                    start  = 1'b1;
                    verify = 1'b1;
                    @(negedge clk);
                    start  = 1'b0;
                    verify = 1'b0;
                end
            end
        join
        check({t.tag, " shifts"}, m_shifts, CL);
        check({t.tag, " first shift cycle"}, m_first, 2);
        check({t.tag, " done cycle"}, m_done_n, CL + 2 + t.gap);
        check({t.tag, " stall cycles"}, m_stall, t.gap);
        check({t.tag, " busy cycles"}, m_busy_cyc, CL + 2 + t.gap);
        check({t.tag, " mismatch_cnt"}, m_mm, t.exp_mm);
        check({t.tag, " chain contents"}, chain, exp_chain);
        @(negedge clk);
        check({t.tag, " idle busy/cfg/done"}, {busy, config_enable, done}, 0);
        check({t.tag, " mismatch hold"}, mismatch_cnt, t.exp_mm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        int n;
        int tmo;
        wif.word_valid = 1'b0;
        wif.word_data  = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset word_ready", wif.word_ready, 0);
        check("reset ccff_head", ccff_head, 0);
        check("reset prog_clk_en", prog_clk_en, 0);
        check("reset config_enable", config_enable, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset mismatch_cnt", mismatch_cnt, 0);
        rst = 1'b0;

        vecs[0] = '{24'hA53CF0, 1'b0, 0, 1'b0, 0, "load"};
        vecs[1] = '{24'hA53CF0, 1'b0, 3, 1'b0, 0, "stall"};
        vecs[2] = '{24'hA53CF0, 1'b1, 0, 1'b0, 0, "verify same"};
        vecs[3] = '{24'h5AC30F, 1'b1, 0, 1'b0, VEN ? 20 : 0, "verify inverted"};
        vecs[4] = '{24'hA53CF0, 1'b0, 0, 1'b1, 0, "reload with busy start"};
        vecs[5] = '{24'hA53DF0, 1'b1, 0, 1'b0, VEN ? 1 : 0, "verify one bit off"};
        for (int i = 0; i < 6; i++) run_pass(vecs[i]);

        wif.word_valid = 1'b1;
        wif.word_data  = 8'hA5;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (wif.word_ready || prog_clk_en || busy) cnt++;
        end
        check("idle word not acknowledged", cnt, 0);
        wif.word_valid = 1'b0;

        start_pass(1'b0);
        wif.word_valid = 1'b1;
        wif.word_data  = 8'hA5;
        n = 0;
        tmo = 0;
        while (n < 7 && tmo < 100) begin
            if (prog_clk_en) n++;
            if (n < 7) begin
                @(negedge clk);
                tmo++;
            end
        end
        check("reset-mid-pass reached shift 7", n, 7);
        rst = 1'b1;
        #1;
        check("mid reset outputs", {wif.word_ready, ccff_head, prog_clk_en, config_enable, busy, done}, 0);
        check("mid reset mismatch_cnt", mismatch_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        wif.word_valid = 1'b0;
        vecs[0].tag = "after reset";
        run_pass(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
